// File: rtl/ddr2_init_monitor_if.sv
// DDR2 command/address/bank pin bus as seen at the SDRAM.
// The controller (or bench) drives it; the monitor only listens.
interface ddr2_init_monitor_if;
  logic        CKE;
  logic [2:0]  COMMAND;  // {RAS,CAS,WE}
  logic [13:0] ADDRESS;
  logic [2:0]  BANK;

  modport master (output CKE, COMMAND, ADDRESS, BANK);
  modport slave  (input  CKE, COMMAND, ADDRESS, BANK);
endinterface

// File: rtl/ddr2_init_monitor.sv
// DDR2 power-up sequence monitor: decodes the pin bus on every clock,
// walks the JEDEC init sequence, captures the four mode registers and
// latches the first protocol violation.
module ddr2_init_monitor #(
  parameter int MIN_GAP    = 2,
  parameter int CKE_SETTLE = 16
) (
  input  logic                CLK_n,
  input  logic                RST,
  ddr2_init_monitor_if.slave  bus,
  output logic                INIT_DONE,
  output logic                ERROR,
  output logic [3:0]          ERR_CODE,
  output logic [3:0]          ERR_STAGE,
  output logic [3:0]          STAGE,
  output logic [13:0]         MR_VAL,
  output logic [13:0]         EMR_VAL,
  output logic [13:0]         EMR2_VAL,
  output logic [13:0]         EMR3_VAL,
  output logic [2:0]          CAS_LATENCY,
  output logic [2:0]          BURST_LEN
);

  localparam int GW = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam int CW = (CKE_SETTLE < 1) ? 1 : $clog2(CKE_SETTLE + 1);

  typedef enum logic [2:0] {
    C_MRST = 3'd0, C_ARSR = 3'd1, C_PRCH = 3'd2, C_ACTV = 3'd3,
    C_WRTE = 3'd4, C_READ = 3'd5, C_BTRM = 3'd6, C_NOOP = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ST_PRE0, ST_EMR2, ST_EMR3, ST_EMR1, ST_MR_DLL, ST_PRE1, ST_REF0,
    ST_REF1, ST_MR, ST_OCD_DEF, ST_OCD_EXIT, ST_FIN, ST_DONE
  } stage_e;

  stage_e          stage;
  cmd_e            cmd;
  logic [GW-1:0]   gap_q, gap_now;
  logic [CW-1:0]   cke_q;
  cmd_e            exp_cmd;
  logic [2:0]      exp_bank;
  logic            chk_bank, addr_ok, is_cmd, done_mode, accept;
  logic [3:0]      err_nx;

  assign cmd         = cmd_e'(bus.COMMAND);
  assign STAGE       = stage;
  assign CAS_LATENCY = MR_VAL[6:4];
  assign BURST_LEN   = MR_VAL[2:0];

  // Distance from the last non-NOOP to the command sampled now; the
  // register holds 0 right after a command, so add one and saturate.
  always_comb begin
    gap_now = (gap_q >= GW'(MIN_GAP)) ? GW'(MIN_GAP) : gap_q + 1'b1;
  end

  // Per-stage expectation and first-violation priority encode.
  always_comb begin
    exp_cmd  = C_NOOP;
    exp_bank = 3'd0;
    chk_bank = 1'b0;
    addr_ok  = 1'b1;
    case (stage)
      ST_PRE0, ST_PRE1: begin exp_cmd = C_PRCH; addr_ok = bus.ADDRESS[10]; end
      ST_EMR2:     begin exp_cmd = C_MRST; chk_bank = 1'b1; exp_bank = 3'd2; end
      ST_EMR3:     begin exp_cmd = C_MRST; chk_bank = 1'b1; exp_bank = 3'd3; end
      ST_EMR1:     begin exp_cmd = C_MRST; chk_bank = 1'b1; exp_bank = 3'd1;
                         addr_ok = ~bus.ADDRESS[0]; end
      ST_MR_DLL:   begin exp_cmd = C_MRST; chk_bank = 1'b1; exp_bank = 3'd0;
                         addr_ok = bus.ADDRESS[8]; end
      ST_REF0, ST_REF1: exp_cmd = C_ARSR;
      ST_MR:       begin exp_cmd = C_MRST; chk_bank = 1'b1; exp_bank = 3'd0;
                         addr_ok = ~bus.ADDRESS[8]; end
      ST_OCD_DEF:  begin exp_cmd = C_MRST; chk_bank = 1'b1; exp_bank = 3'd1;
                         addr_ok = &bus.ADDRESS[9:7]; end
      ST_OCD_EXIT: begin exp_cmd = C_MRST; chk_bank = 1'b1; exp_bank = 3'd1;
                         addr_ok = ~|bus.ADDRESS[9:7]; end
      default: ;
    endcase

    is_cmd    = (cmd != C_NOOP);
    done_mode = (stage == ST_FIN) || (stage == ST_DONE);
    err_nx    = 4'd0;
    if (is_cmd) begin
      if (!bus.CKE || cke_q < CW'(CKE_SETTLE))          err_nx = 4'd5;
      else if (gap_now < GW'(MIN_GAP))                  err_nx = 4'd4;
      else if (!done_mode) begin
        if (cmd inside {C_ACTV, C_READ, C_WRTE, C_BTRM}) err_nx = 4'd6;
        else if (cmd != exp_cmd)                        err_nx = 4'd1;
        else if (chk_bank && bus.BANK != exp_bank)      err_nx = 4'd2;
        else if (!addr_ok)                              err_nx = 4'd3;
      end
    end
    accept = is_cmd && (err_nx == 4'd0) && !done_mode && !ERROR;
  end

  // Command spacing and CKE settle counters, both saturating.
  always_ff @(posedge CLK_n or negedge RST) begin
    if (!RST) begin
      gap_q <= GW'(MIN_GAP);
      cke_q <= '0;
    end else begin
      gap_q <= is_cmd ? '0 : gap_now;
      if (!bus.CKE)                      cke_q <= '0;
      else if (cke_q < CW'(CKE_SETTLE))  cke_q <= cke_q + 1'b1;
    end
  end

  // Stage machine, register capture and sticky error latch.
  always_ff @(posedge CLK_n or negedge RST) begin
    if (!RST) begin
      stage     <= ST_PRE0;
      INIT_DONE <= 1'b0;
      ERROR     <= 1'b0;
      ERR_CODE  <= 4'd0;
      ERR_STAGE <= 4'd0;
      MR_VAL    <= '0;
      EMR_VAL   <= '0;
      EMR2_VAL  <= '0;
      EMR3_VAL  <= '0;
    end else begin
      // Captures happen even on failing MRSTs so the written value is visible.
      if (cmd == C_MRST && !bus.BANK[2]) begin
        case (bus.BANK[1:0])
          2'd0: MR_VAL   <= bus.ADDRESS;
          2'd1: EMR_VAL  <= bus.ADDRESS;
          2'd2: EMR2_VAL <= bus.ADDRESS;
          default: EMR3_VAL <= bus.ADDRESS;
        endcase
      end
      if (!ERROR) begin
        if (err_nx != 4'd0) begin
          ERROR     <= 1'b1;
          ERR_CODE  <= err_nx;
          ERR_STAGE <= stage;
        end else if (stage == ST_FIN) begin
          stage <= ST_DONE;
        end else if (accept) begin
          stage <= stage_e'(stage + 4'd1);
          if (stage == ST_OCD_EXIT) INIT_DONE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr2_init_monitor.sv
// Directed bench for ddr2_init_monitor: table-driven legal init sequence
// plus hand-written error and boundary sequences.
module tb_ddr2_init_monitor;

  logic CLK_n = 1'b0;
  logic RST   = 1'b0;
  logic        INIT_DONE, ERROR;
  logic [3:0]  ERR_CODE, ERR_STAGE, STAGE;
  logic [13:0] MR_VAL, EMR_VAL, EMR2_VAL, EMR3_VAL;
  logic [2:0]  CAS_LATENCY, BURST_LEN;

  localparam logic [2:0] NOOP = 3'd7, ACTV = 3'd3, READ = 3'd5,
                         PRCH = 3'd2, ARSR = 3'd1, MRST = 3'd0;

  ddr2_init_monitor_if bus_if ();

  ddr2_init_monitor #(.MIN_GAP(2), .CKE_SETTLE(16)) dut (
    .CLK_n(CLK_n), .RST(RST), .bus(bus_if.slave),
    .INIT_DONE(INIT_DONE), .ERROR(ERROR), .ERR_CODE(ERR_CODE),
    .ERR_STAGE(ERR_STAGE), .STAGE(STAGE), .MR_VAL(MR_VAL),
    .EMR_VAL(EMR_VAL), .EMR2_VAL(EMR2_VAL), .EMR3_VAL(EMR3_VAL),
    .CAS_LATENCY(CAS_LATENCY), .BURST_LEN(BURST_LEN)
  );

  always #5 CLK_n = ~CLK_n;

  typedef struct {
    logic [2:0]  cmd;
    logic [13:0] addr;
    logic [2:0]  bank;
    logic [3:0]  exp_stage;
  } vec_t;

  vec_t seq [11];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [13:0] a, input logic [2:0] b);
    bus_if.COMMAND = c;
    bus_if.ADDRESS = a;
    bus_if.BANK    = b;
  endtask

  // NOOP for n cycles (inputs change on negedge)
  task automatic idle(input int n);
    repeat (n) begin @(negedge CLK_n); drive(NOOP, 14'h0, 3'd0); end
  endtask

  // One command, then NOOP; returns on the negedge after it was sampled
  task automatic issue(input logic [2:0] c, input logic [13:0] a, input logic [2:0] b);
    @(negedge CLK_n); drive(c, a, b);
    @(negedge CLK_n); drive(NOOP, 14'h0, 3'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK_n);
    RST = 1'b0; bus_if.CKE = 1'b0; drive(NOOP, 14'h0, 3'd0);
    repeat (2) @(negedge CLK_n);
    RST = 1'b1;
  endtask

  // Reset, raise CKE long enough, then walk the first n table entries legally
  task automatic prefix(input int n);
    do_reset();
    bus_if.CKE = 1'b1;
    idle(40);
    for (int i = 0; i < n; i++) begin
      idle(32);
      issue(seq[i].cmd, seq[i].addr, seq[i].bank);
    end
  endtask

  initial begin
    seq[0]  = '{PRCH, 14'h400, 3'd1, 4'd1};
    seq[1]  = '{MRST, 14'h000, 3'd2, 4'd2};
    seq[2]  = '{MRST, 14'h000, 3'd3, 4'd3};
    seq[3]  = '{MRST, 14'h780, 3'd1, 4'd4};
    seq[4]  = '{MRST, 14'h532, 3'd0, 4'd5};
    seq[5]  = '{PRCH, 14'h400, 3'd0, 4'd6};
    seq[6]  = '{ARSR, 14'h000, 3'd0, 4'd7};
    seq[7]  = '{ARSR, 14'h000, 3'd0, 4'd8};
    seq[8]  = '{MRST, 14'h432, 3'd0, 4'd9};
    seq[9]  = '{MRST, 14'h780, 3'd1, 4'd10};
    seq[10] = '{MRST, 14'h400, 3'd1, 4'd11};

    bus_if.CKE = 1'b0;
    drive(NOOP, 14'h0, 3'd0);

    // ---- legal sequence ----
    do_reset();
    chk("rst_stage", STAGE, 0);
    chk("rst_error", ERROR, 0);
    chk("rst_done", INIT_DONE, 0);
    chk("rst_mr", MR_VAL, 0);
    chk("rst_code", ERR_CODE, 0);
    bus_if.CKE = 1'b1;
    idle(40);
    for (int i = 0; i < 11; i++) begin
      idle(32);
      issue(seq[i].cmd, seq[i].addr, seq[i].bank);
      chk($sformatf("seq_stage%0d", i), STAGE, seq[i].exp_stage);
      chk($sformatf("seq_err%0d", i), ERROR, 0);
    end
    chk("init_done", INIT_DONE, 1);
    idle(1);
    chk("stage_done", STAGE, 12);
    chk("mr_val", MR_VAL, 14'h432);
    chk("emr_val", EMR_VAL, 14'h400);
    chk("emr2_val", EMR2_VAL, 0);
    chk("emr3_val", EMR3_VAL, 0);
    chk("cas_lat", CAS_LATENCY, 3);
    chk("burst_len", BURST_LEN, 2);

    // ---- DONE mode MR rewrite, then async reset ----
    idle(3);
    issue(MRST, 14'h452, 3'd0);
    chk("done_mr", MR_VAL, 14'h452);
    chk("done_cl", CAS_LATENCY, 5);
    chk("done_err", ERROR, 0);
    chk("done_still", INIT_DONE, 1);
    idle(2);
    #2 RST = 1'b0;
    #1;
    chk("arst_done", INIT_DONE, 0);
    chk("arst_stage", STAGE, 0);
    chk("arst_mr", MR_VAL, 0);
    chk("arst_emr", EMR_VAL, 0);
    @(negedge CLK_n); RST = 1'b1;

    // ---- stage-4 MR without DLL reset -> code 3 ----
    prefix(4);
    idle(32);
    issue(MRST, 14'h432, 3'd0);
    chk("a8_error", ERROR, 1);
    chk("a8_code", ERR_CODE, 3);
    chk("a8_estage", ERR_STAGE, 4);
    chk("a8_mr", MR_VAL, 14'h432);
    for (int i = 5; i < 11; i++) begin
      idle(32);
      issue(seq[i].cmd, seq[i].addr, seq[i].bank);
    end
    idle(2);
    chk("a8_nodone", INIT_DONE, 0);
    chk("a8_frozen", STAGE, 4);

    // ---- gap exactly MIN_GAP is legal, gap 1 is not ----
    prefix(1);
    @(negedge CLK_n); drive(MRST, 14'h0, 3'd2);   // gap from PRCH well over 2
    @(negedge CLK_n); drive(NOOP, 14'h0, 3'd0);
    @(negedge CLK_n); drive(MRST, 14'h0, 3'd3);   // gap 2
    @(negedge CLK_n); drive(NOOP, 14'h0, 3'd0);
    chk("gap2_stage", STAGE, 3);
    chk("gap2_err", ERROR, 0);

    prefix(0);
    @(negedge CLK_n); drive(PRCH, 14'h400, 3'd0);
    @(negedge CLK_n); drive(ARSR, 14'h0, 3'd0);   // gap 1
    @(negedge CLK_n); drive(NOOP, 14'h0, 3'd0);
    chk("gap1_code", ERR_CODE, 4);
    chk("gap1_estage", ERR_STAGE, 1);

    // ---- CKE low / not settled -> code 5 ----
    do_reset();
    idle(40);
    issue(PRCH, 14'h400, 3'd1);
    chk("ckelo_code", ERR_CODE, 5);
    chk("ckelo_estage", ERR_STAGE, 0);

    do_reset();
    @(negedge CLK_n); bus_if.CKE = 1'b1; drive(NOOP, 14'h0, 3'd0);
    idle(4);
    issue(PRCH, 14'h400, 3'd1);                    // 5 cycles after CKE rise
    chk("cke5_code", ERR_CODE, 5);
    chk("cke5_stage", STAGE, 0);

    do_reset();
    @(negedge CLK_n); bus_if.CKE = 1'b1; drive(NOOP, 14'h0, 3'd0);
    idle(15);
    issue(PRCH, 14'h400, 3'd1);                    // exactly CKE_SETTLE
    chk("cke16_err", ERROR, 0);
    chk("cke16_stage", STAGE, 1);

    // ---- data command before DONE -> code 6, first error sticks ----
    prefix(6);
    idle(32);
    issue(READ, 14'h0, 3'd0);
    chk("read_code", ERR_CODE, 6);
    chk("read_estage", ERR_STAGE, 6);
    idle(32);
    issue(MRST, 14'h123, 3'd0);
    chk("sticky_code", ERR_CODE, 6);
    chk("sticky_error", ERROR, 1);
    chk("fail_capture", MR_VAL, 14'h123);
    idle(32);
    issue(ACTV, 14'h0, 3'd0);
    chk("sticky_stage", STAGE, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
